// File: rtl/sys_reboot.sv
// Reboot and user-button controller: debounces the push-button, classifies short/long presses
// and drives SB_WARMBOOT after a fixed arming delay.
module sys_reboot #(
    parameter int unsigned PRESCALE    = 30720,
    parameter int unsigned DEBOUNCE_MS = 5,
    parameter int unsigned LONG_MS     = 2000,
    parameter int unsigned ARM_MS      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic       req_stb,
    input  logic [1:0] req_sel,
    output logic       btn_short,
    output logic       btn_long,
    output logic       busy,
    output logic       boot,
    output logic [1:0] sel
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam int unsigned DW = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned LW = $clog2(LONG_MS + 1);
    localparam int unsigned AW = $clog2(ARM_MS + 1);

    typedef enum logic [1:0] {StIdle, StArm, StBoot} state_e;

    logic          sync1_q, sync2_q;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic          db_q, db_d, db_prev_q;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          press_edge, release_edge;
    logic [LW-1:0] timer_q, timer_d;
    logic          btn_short_q, btn_short_d;
    logic          btn_long_q, btn_long_d;
    state_e        state_q, state_d;
    logic [AW-1:0] arm_q, arm_d;
    logic [1:0]    sel_q, sel_d;
    logic          busy_q, boot_q;

    assign tick    = (presc_q == PW'(PRESCALE - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q == db_q) begin
            db_cnt_d = '0;
        end else if (tick) begin
            if (db_cnt_q == DW'(DEBOUNCE_MS - 1)) begin
                db_d     = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign press_edge   = db_prev_q & ~db_q;
    assign release_edge = ~db_prev_q & db_q;

    // Timer saturates at LONG_MS, so btn_long can fire only once per press.
    always_comb begin
        timer_d     = timer_q;
        btn_long_d  = 1'b0;
        btn_short_d = 1'b0;
        if (press_edge) begin
            timer_d = '0;
        end else if (!db_q && tick && (timer_q != LW'(LONG_MS))) begin
            timer_d    = timer_q + 1'b1;
            btn_long_d = (timer_q == LW'(LONG_MS - 1));
        end
        if (release_edge) begin
            btn_short_d = (timer_q < LW'(LONG_MS));
        end
    end

    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        sel_d   = sel_q;
        unique case (state_q)
            StIdle: begin
                if (req_stb) begin
                    sel_d   = req_sel;
                    state_d = StArm;
                    arm_d   = '0;
                end else if (btn_long_q) begin
                    sel_d   = 2'b01;
                    state_d = StArm;
                    arm_d   = '0;
                end
            end
            StArm: begin
                if (tick) begin
                    if (arm_q == AW'(ARM_MS - 1)) begin
                        state_d = StBoot;
                    end else begin
                        arm_d = arm_q + 1'b1;
                    end
                end
            end
            StBoot:  state_d = StBoot;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            presc_q     <= '0;
            db_q        <= 1'b1;
            db_prev_q   <= 1'b1;
            db_cnt_q    <= '0;
            timer_q     <= '0;
            btn_short_q <= 1'b0;
            btn_long_q  <= 1'b0;
            state_q     <= StIdle;
            arm_q       <= '0;
            sel_q       <= 2'b00;
            busy_q      <= 1'b0;
            boot_q      <= 1'b0;
        end else begin
            sync1_q     <= btn_n;
            sync2_q     <= sync1_q;
            presc_q     <= presc_d;
            db_q        <= db_d;
            db_prev_q   <= db_q;
            db_cnt_q    <= db_cnt_d;
            timer_q     <= timer_d;
            btn_short_q <= btn_short_d;
            btn_long_q  <= btn_long_d;
            state_q     <= state_d;
            arm_q       <= arm_d;
            sel_q       <= sel_d;
            busy_q      <= (state_d != StIdle);
            boot_q      <= (state_d == StBoot);
        end
    end

    assign btn_short = btn_short_q;
    assign btn_long  = btn_long_q;
    assign busy      = busy_q;
    assign boot      = boot_q;
    assign sel       = sel_q;

endmodule

// File: doc/sys_reboot.md
# sys_reboot

Reboot and user-button controller in the `clk_sys` domain, downstream of the system clock/reset manager. It consumes the 30.72 MHz system clock and its synchronous-release system reset. It debounces the board push-button, classifies short and long presses, and accepts reboot requests from the USB control logic. After a fixed arming delay it drives the `SB_WARMBOOT` `BOOT`/`S1:S0` inputs to jump to the selected bitstream image.

## Interface
Parameters:
- `PRESCALE`, 30720: `clk` cycles per internal 1 ms tick; must be ≥ 2.
- `DEBOUNCE_MS`, 5: ticks the synchronized button must differ from the debounced level before the debounced level flips; must be ≥ 1.
- `LONG_MS`, 2000: held duration, in ticks, that qualifies as a long press; must be ≥ 2.
- `ARM_MS`, 10: ticks between accepting a reboot and asserting `boot`; must be ≥ 1.

Ports:
- `clk` in 1: system clock (`clk_sys`).
- `rst` in 1: asynchronous, active-high reset (`rst_sys`).
- `btn_n` in 1: raw push-button, active-low, asynchronous to `clk`.
- `req_stb` in 1: single-cycle reboot request strobe.
- `req_sel` in 2: image index for `req_stb`, sampled only when `req_stb`=1.
- `btn_short` out 1: one-cycle pulse on release of a short press.
- `btn_long` out 1: one-cycle pulse when a held press reaches `LONG_MS`.
- `busy` out 1: a reboot is pending or in progress.
- `boot` out 1: to `SB_WARMBOOT.BOOT`.
- `sel` out 2: to `SB_WARMBOOT.S1:S0`.

## Operation
- **Reset values:** `btn_short`=0, `btn_long`=0, `busy`=0, `boot`=0, `sel`=2'b00. The synchronizer and debounced level reset to 1 (released). All counters reset to 0. The FSM resets to IDLE.
- **Synchronizer:** `btn_n` passes through a 2-FF synchronizer.
- **Tick:** a prescaler counts 0..`PRESCALE`-1 and wraps. `tick`=1 in the cycle the count equals `PRESCALE`-1.
- **Debounce:**
  - A counter clears in any cycle where the synchronized level equals the debounced level.
  - Otherwise it increments on `tick`.
  - When it reaches `DEBOUNCE_MS`, the debounced level takes the synchronized value and the counter clears.
- **Press timer:**
  - Clears on a debounced press edge (1→0).
  - While pressed, it increments on `tick` and saturates at `LONG_MS`.
  - `btn_long` pulses in the cycle the timer transitions to `LONG_MS`, once per press.
  - On a debounced release edge (0→1): `btn_short` pulses if the timer is < `LONG_MS`; no pulse otherwise.
- **FSM states:** IDLE, ARM, BOOT.
  - **IDLE:**
    - `req_stb`=1: latch `sel`←`req_sel` and go to ARM.
    - Else, `btn_long` event: latch `sel`←2'b01 (DFU bootloader image) and go to ARM.
    - Both in the same cycle: `req_stb` wins.
    - On entering ARM, the arm counter clears.
  - **ARM:** the arm counter increments on `tick`. A `tick` while the counter is `ARM_MS`-1 moves the FSM to BOOT.
  - **BOOT:** `boot`=1. This state is terminal; only `rst` exits it.
- **Requests while busy:** `req_stb` and long presses in ARM or BOOT are ignored; `sel` does not change. Button pulses (`btn_short`, `btn_long`) still occur.
- **Outputs:** `busy` = (state ≠ IDLE). `boot` = (state = BOOT). `sel` holds its latched value until `rst`.
- **Reset mid-operation:** asserting `rst` in ARM or BOOT immediately (asynchronously) drops `boot` and `busy`, clears `sel`, and aborts the reboot.

## Timing
- Every output is registered.
- `req_stb` in cycle N → `busy`=1 and `sel` valid at N+1.
- `boot` rises one cycle after the `ARM_MS`-th tick that occurs strictly after the ARM entry cycle. The delay from `req_stb` to `boot` is therefore between (`ARM_MS`-1)·`PRESCALE`+2 and `ARM_MS`·`PRESCALE`+1 cycles.
- Button latency:
  - 2 cycles of synchronizer, plus `DEBOUNCE_MS` ticks of debounce (the first tick may be partial), plus 1 cycle to the debounced edge.
  - `btn_short` appears one cycle after the debounced release edge.
  - `btn_long` appears in the cycle after the `LONG_MS`-th tick following the press edge.
- `btn_long` → ARM entry on the following cycle.
- Glitches on `btn_n` shorter than one tick never change the debounced level.

## Test plan
Bench parameters: `PRESCALE`=4, `DEBOUNCE_MS`=2, `LONG_MS`=8, `ARM_MS`=3.
1. **Reset:** hold `rst`, then release → all outputs 0 and `sel`=00. Assert `rst` asynchronously mid-cycle while in BOOT → `boot` falls without waiting for a clock edge.
2. **Software request:** `req_stb`=1 with `req_sel`=2'b10 at cycle N → `busy`=1 and `sel`=10 at N+1. `boot` rises within N+10..N+13 and stays high.
3. **Short press:** `btn_n` low for 20 cycles, then high → one `btn_short` pulse after release debounce. No `btn_long`, `busy` stays 0.
4. **Glitch rejection:** 3-cycle low pulses on `btn_n`, repeated every 10 cycles → no pulses and no state change.
5. **Long press:** `btn_n` held low for 60 cycles → exactly one `btn_long`, then `busy`=1 and `sel`=01, then `boot`=1. Release → no `btn_short`.
6. **Collisions:**
   - `req_stb` (`req_sel`=11) in the same cycle as the `btn_long` pulse → `sel`=11.
   - A second `req_stb` (`req_sel`=00) during ARM → `sel` stays 11.
